// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the in-order pipeline.
// Merges per-source stall requests into a thermometer stall vector
// (stall[0]=PC ... stall[5]=WB), sequences redirect flushes with a post-flush
// drain that holds PC+IF, and runs a sticky stall watchdog.
// Optional build macro PIPE_HAZARD_CTRL_PERF_EN adds the stall-cycle and
// flush-count performance counters; without it both outputs are tied to 0.
module pipe_hazard_ctrl #(
  parameter int unsigned         NSTAGE    = 6,
  parameter int unsigned         NREQ      = 3,
  parameter logic [4*NREQ-1:0]   REQ_STAGE = 12'h223,
  parameter int unsigned         DRAIN_CYC = 2,
  parameter int unsigned         TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stallreq,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  output logic [NSTAGE-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              busy,
  output logic              stall_timeout,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       flush_count
);

  localparam logic [3:0]      K_MAX      = 4'(NSTAGE - 1);
  localparam bit              HAS_DRAIN  = (DRAIN_CYC > 0);
  localparam int unsigned     DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYC);
  localparam bit              WD_EN      = (TIMEOUT > 0);
  localparam int unsigned     WDW        = WD_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0]  WD_MAX     = WDW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DW-1:0]       r_drain;
  logic [31:0]         r_new_pc;
  logic [WDW-1:0]      r_wd;
  logic [WDW-1:0]      w_wd_next;
  logic                r_timeout;
  logic                w_any;
  logic [3:0]          w_k;
  logic [NSTAGE-1:0]   w_merge;
  logic [NSTAGE-1:0]   w_hold;
  logic [NSTAGE-1:0]   w_stall;

  // Merge: deepest frozen stage among asserted requests, expanded to a thermometer
  always_comb begin
    w_any = 1'b0;
    w_k   = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (stallreq[j]) begin
        w_any = 1'b1;
        if (REQ_STAGE[4*j +: 4] > w_k) w_k = REQ_STAGE[4*j +: 4];
      end
    end
    if (w_k > K_MAX) w_k = K_MAX;
    w_merge = '0;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      w_merge[i] = w_any && (4'(i) <= w_k);
    end
    w_hold      = '0;
    w_hold[1:0] = 2'b11;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next state; a redirect in any state (re)starts the flush
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (flush_req) w_state_next = S_FLUSH;
      S_FLUSH: begin
        if (flush_req)      w_state_next = S_FLUSH;
        else if (HAS_DRAIN) w_state_next = S_DRAIN;
        else                w_state_next = S_IDLE;
      end
      S_DRAIN: begin
        if (flush_req)                 w_state_next = S_FLUSH;
        else if (r_drain == DW'(1))    w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs; stall is forced low while rst is asserted
  always_comb begin
    flush   = (r_state == S_FLUSH);
    busy    = (r_state != S_IDLE);
    w_stall = '0;
    unique case (r_state)
      S_IDLE:  w_stall = w_merge;
      S_FLUSH: w_stall = '0;
      S_DRAIN: w_stall = w_merge | w_hold;
      default: w_stall = '0;
    endcase
    if (rst) w_stall = '0;
    stall = w_stall;
  end

  // Drain down-counter, reloaded on every FLUSH cycle
  always_ff @(posedge clk) begin
    if (rst)                                    r_drain <= '0;
    else if (r_state == S_FLUSH)                r_drain <= DRAIN_LOAD;
    else if (r_state == S_DRAIN && r_drain != '0) r_drain <= r_drain - DW'(1);
  end

  // Redirect target capture; latest accepted request wins
  always_ff @(posedge clk) begin
    if (rst)            r_new_pc <= '0;
    else if (flush_req) r_new_pc <= flush_pc;
  end

  assign new_pc = r_new_pc;

  // Watchdog next count: consecutive stalled cycles outside FLUSH, saturating
  always_comb begin
    w_wd_next = r_wd;
    if (r_state == S_FLUSH || w_stall == '0) w_wd_next = '0;
    else if (r_wd != WD_MAX)                 w_wd_next = r_wd + WDW'(1);
  end

  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd <= w_wd_next;
      if (WD_EN && w_wd_next == WD_MAX) r_timeout <= 1'b1;
    end
  end

  assign stall_timeout = r_timeout;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  // Performance counters, free-running with wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall != '0) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (flush_req)     r_flush_count  <= r_flush_count + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (NSTAGE=6, NREQ=3, DRAIN_CYC=2, TIMEOUT=8).
// Each step pushes the expected outputs to a scoreboard as stimulus is driven;
// the entry is popped and compared on the following falling edge.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  stallreq;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  pipe_hazard_ctrl #(
    .NSTAGE(6), .NREQ(3), .REQ_STAGE(12'h223), .DRAIN_CYC(2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
    .flush_pc(flush_pc), .stall(stall), .flush(flush), .new_pc(new_pc),
    .busy(busy), .stall_timeout(stall_timeout), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [2:0]  req;
    logic        fr;
    logic [31:0] pc;
    logic [5:0]  st;
    logic        fl;
    logic        bz;
    logic        to;
  } step_t;

  // {stall, flush, busy, stall_timeout, new_pc, stall_cycles, flush_count}
  logic [88:0] sb[$];
  logic [88:0] e;
  logic [88:0] obs;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_sc = '0;
  logic [15:0] m_fc = '0;

  task automatic test_reset();
    step_t s[$];
    s.push_back(step_t'{1'b1, 3'b111, 1'b1, 32'hDEAD_BEEF, 6'b0, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b1, 3'b111, 1'b1, 32'hDEAD_BEEF, 6'b0, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b0, 1'b0, 1'b0, 1'b0});
    foreach (s[i]) begin
      rst = s[i].rst; stallreq = s[i].req; flush_req = s[i].fr; flush_pc = s[i].pc;
      sb.push_back({s[i].st, s[i].fl, s[i].bz, s[i].to, m_pc, PERF ? m_sc : 32'd0, PERF ? m_fc : 16'd0});
      @(negedge clk);
      e = sb.pop_front();
      obs = {stall, flush, busy, stall_timeout, new_pc, stall_cycles, flush_count};
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL reset[%0d] got %h need %h", i, obs, e);
      end
      @(posedge clk); #1;
      if (s[i].rst) begin m_pc = '0; m_sc = '0; m_fc = '0; end
      else begin
        if (s[i].fr) begin m_pc = s[i].pc; m_fc = m_fc + 16'd1; end
        if (s[i].st != '0) m_sc = m_sc + 32'd1;
      end
    end
  endtask

  task automatic test_merge();
    step_t s[$];
    s.push_back(step_t'{1'b0, 3'b001, 1'b0, 32'h0, 6'b001111, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b110, 1'b0, 32'h0, 6'b000111, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b111, 1'b0, 32'h0, 6'b001111, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b010, 1'b0, 32'h0, 6'b000111, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b100, 1'b0, 32'h0, 6'b000111, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b011, 1'b0, 32'h0, 6'b001111, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0, 1'b0});
    foreach (s[i]) begin
      rst = s[i].rst; stallreq = s[i].req; flush_req = s[i].fr; flush_pc = s[i].pc;
      sb.push_back({s[i].st, s[i].fl, s[i].bz, s[i].to, m_pc, PERF ? m_sc : 32'd0, PERF ? m_fc : 16'd0});
      @(negedge clk);
      e = sb.pop_front();
      obs = {stall, flush, busy, stall_timeout, new_pc, stall_cycles, flush_count};
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL merge[%0d] req=%b got %h need %h", i, s[i].req, obs, e);
      end
      @(posedge clk); #1;
      if (s[i].rst) begin m_pc = '0; m_sc = '0; m_fc = '0; end
      else begin
        if (s[i].fr) begin m_pc = s[i].pc; m_fc = m_fc + 16'd1; end
        if (s[i].st != '0) m_sc = m_sc + 32'd1;
      end
    end
  endtask

  // Holds req0 for 'hold' cycles then releases for two cycles
  task automatic test_watchdog(input int unsigned hold, input logic fires);
    step_t s[$];
    for (int unsigned c = 0; c < hold; c++)
      s.push_back(step_t'{1'b0, 3'b001, 1'b0, 32'h0, 6'b001111, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0, fires});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0, fires});
    foreach (s[i]) begin
      rst = s[i].rst; stallreq = s[i].req; flush_req = s[i].fr; flush_pc = s[i].pc;
      sb.push_back({s[i].st, s[i].fl, s[i].bz, s[i].to, m_pc, PERF ? m_sc : 32'd0, PERF ? m_fc : 16'd0});
      @(negedge clk);
      e = sb.pop_front();
      obs = {stall, flush, busy, stall_timeout, new_pc, stall_cycles, flush_count};
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL watchdog_hold%0d[%0d] got %h need %h", hold, i, obs, e);
      end
      @(posedge clk); #1;
      if (s[i].rst) begin m_pc = '0; m_sc = '0; m_fc = '0; end
      else begin
        if (s[i].fr) begin m_pc = s[i].pc; m_fc = m_fc + 16'd1; end
        if (s[i].st != '0) m_sc = m_sc + 32'd1;
      end
    end
  endtask

  task automatic test_flush();
    step_t s[$];
    s.push_back(step_t'{1'b0, 3'b000, 1'b1, 32'hBFC0_0380, 6'b000000, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b001, 1'b0, 32'h0,         6'b000000, 1'b1, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000011, 1'b0, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b110, 1'b0, 32'h0,         6'b000111, 1'b0, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0});
    foreach (s[i]) begin
      rst = s[i].rst; stallreq = s[i].req; flush_req = s[i].fr; flush_pc = s[i].pc;
      sb.push_back({s[i].st, s[i].fl, s[i].bz, s[i].to, m_pc, PERF ? m_sc : 32'd0, PERF ? m_fc : 16'd0});
      @(negedge clk);
      e = sb.pop_front();
      obs = {stall, flush, busy, stall_timeout, new_pc, stall_cycles, flush_count};
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL flush[%0d] got %h need %h", i, obs, e);
      end
      @(posedge clk); #1;
      if (s[i].rst) begin m_pc = '0; m_sc = '0; m_fc = '0; end
      else begin
        if (s[i].fr) begin m_pc = s[i].pc; m_fc = m_fc + 16'd1; end
        if (s[i].st != '0) m_sc = m_sc + 32'd1;
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    s.push_back(step_t'{1'b0, 3'b000, 1'b1, 32'h1111_0000, 6'b000000, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000000, 1'b1, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b1, 32'h8000_0000, 6'b000011, 1'b0, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000000, 1'b1, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000011, 1'b0, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000011, 1'b0, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b1, 32'hA000_0000, 6'b000000, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b1, 32'hB000_0000, 6'b000000, 1'b1, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000000, 1'b1, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b001, 1'b0, 32'h0,         6'b001111, 1'b0, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000011, 1'b0, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0});
    foreach (s[i]) begin
      rst = s[i].rst; stallreq = s[i].req; flush_req = s[i].fr; flush_pc = s[i].pc;
      sb.push_back({s[i].st, s[i].fl, s[i].bz, s[i].to, m_pc, PERF ? m_sc : 32'd0, PERF ? m_fc : 16'd0});
      @(negedge clk);
      e = sb.pop_front();
      obs = {stall, flush, busy, stall_timeout, new_pc, stall_cycles, flush_count};
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL back_to_back[%0d] got %h need %h", i, obs, e);
      end
      @(posedge clk); #1;
      if (s[i].rst) begin m_pc = '0; m_sc = '0; m_fc = '0; end
      else begin
        if (s[i].fr) begin m_pc = s[i].pc; m_fc = m_fc + 16'd1; end
        if (s[i].st != '0) m_sc = m_sc + 32'd1;
      end
    end
  endtask

  // Entered with stall_timeout already set; reset during FLUSH clears everything
  task automatic test_reset_midflush();
    step_t s[$];
    s.push_back(step_t'{1'b0, 3'b000, 1'b1, 32'hCAFE_0000, 6'b000000, 1'b0, 1'b0, 1'b1});
    s.push_back(step_t'{1'b1, 3'b001, 1'b1, 32'hDEAD_0000, 6'b000000, 1'b1, 1'b1, 1'b1});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0});
    foreach (s[i]) begin
      rst = s[i].rst; stallreq = s[i].req; flush_req = s[i].fr; flush_pc = s[i].pc;
      sb.push_back({s[i].st, s[i].fl, s[i].bz, s[i].to, m_pc, PERF ? m_sc : 32'd0, PERF ? m_fc : 16'd0});
      @(negedge clk);
      e = sb.pop_front();
      obs = {stall, flush, busy, stall_timeout, new_pc, stall_cycles, flush_count};
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL reset_midflush[%0d] got %h need %h", i, obs, e);
      end
      @(posedge clk); #1;
      if (s[i].rst) begin m_pc = '0; m_sc = '0; m_fc = '0; end
      else begin
        if (s[i].fr) begin m_pc = s[i].pc; m_fc = m_fc + 16'd1; end
        if (s[i].st != '0) m_sc = m_sc + 32'd1;
      end
    end
  endtask

  // Three accepted flushes plus five explicitly stalled cycles
  task automatic test_perf();
    step_t s[$];
    s.push_back(step_t'{1'b0, 3'b000, 1'b1, 32'h0000_0100, 6'b000000, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000000, 1'b1, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000011, 1'b0, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000011, 1'b0, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b1, 32'h0000_0200, 6'b000000, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000000, 1'b1, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b1, 32'h0000_0300, 6'b000011, 1'b0, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000000, 1'b1, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000011, 1'b0, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000011, 1'b0, 1'b1, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0});
    for (int unsigned c = 0; c < 5; c++)
      s.push_back(step_t'{1'b0, 3'b100, 1'b0, 32'h0, 6'b000111, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0});
    s.push_back(step_t'{1'b0, 3'b000, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0});
    foreach (s[i]) begin
      rst = s[i].rst; stallreq = s[i].req; flush_req = s[i].fr; flush_pc = s[i].pc;
      sb.push_back({s[i].st, s[i].fl, s[i].bz, s[i].to, m_pc, PERF ? m_sc : 32'd0, PERF ? m_fc : 16'd0});
      @(negedge clk);
      e = sb.pop_front();
      obs = {stall, flush, busy, stall_timeout, new_pc, stall_cycles, flush_count};
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL perf[%0d] got %h need %h", i, obs, e);
      end
      @(posedge clk); #1;
      if (s[i].rst) begin m_pc = '0; m_sc = '0; m_fc = '0; end
      else begin
        if (s[i].fr) begin m_pc = s[i].pc; m_fc = m_fc + 16'd1; end
        if (s[i].st != '0) m_sc = m_sc + 32'd1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; stallreq = '0; flush_req = 1'b0; flush_pc = '0;
    @(posedge clk); #1;
    test_reset();
    test_merge();
    test_watchdog(7, 1'b0);
    test_flush();
    test_back_to_back();
    test_watchdog(8, 1'b1);
    test_reset_midflush();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit got expired need finished");
    $fatal(1, "time limit");
  end

endmodule
